// File: rtl/wddl_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wddl_aes_pkg
// Brief    : Shared types, constants and GF(2^8) helper for the WDDL AES core.
// Revision : 1.0
// ============================================================================
package wddl_aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wddl_rcon_gen.sv
`default_nettype none
// ============================================================================
// Module   : wddl_rcon_gen
// Brief    : AES round-constant register; first advance from zero gives 0x01.
// Revision : 1.0
// ============================================================================
module wddl_rcon_gen
  import wddl_aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (clear_i) begin
      rcon_d = 8'h00;
    end else if (advance_i) begin
      rcon_d = (rcon_q == 8'h00) ? 8'h01 : xtime(rcon_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcon_q <= 8'h00;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule
`default_nettype wire

// File: rtl/wddl_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : wddl_round_seq
// Brief    : Precharge/evaluate phase and round sequencer for WDDL AES-128.
// Revision : 1.0
// ============================================================================
module wddl_round_seq
  import wddl_aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       pre_out,
  output logic       eval_out,
  output logic       load_out,
  output logic [3:0] round_out,
  output logic [7:0] rcon_out,
  output logic       first_out,
  output logic       last_out
);

  localparam int              c_MAXC      = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int              c_CW        = $clog2(c_MAXC + 1);
  localparam logic [c_CW-1:0] c_PRE_LAST  = c_CW'(PRE_CYC - 1);
  localparam logic [c_CW-1:0] c_EVAL_LAST = c_CW'(EVAL_CYC - 1);
  localparam logic [3:0]      c_NR        = 4'(NR);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic [c_CW-1:0] cnt_q;
  logic [c_CW-1:0] cnt_d;
  logic [3:0]      round_q;
  logic [3:0]      round_d;
  logic            w_rcon_clear;
  logic            w_rcon_adv;
  logic            w_active;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    round_d      = round_q;
    w_rcon_clear = 1'b0;
    w_rcon_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d      = ST_PRE;
          cnt_d        = '0;
          round_d      = 4'd0;
          w_rcon_clear = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_q == c_PRE_LAST) begin
          state_d = ST_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        if (cnt_q == c_EVAL_LAST) begin
          cnt_d = '0;
          if (round_q == c_NR) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_PRE;
            round_d    = round_q + 4'd1;
            w_rcon_adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Leaving DONE restores the idle view: round 0, rcon 0x00.
        state_d      = ST_IDLE;
        round_d      = 4'd0;
        w_rcon_clear = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_active  = (state_q == ST_PRE) || (state_q == ST_EVAL);
    busy_out  = (state_q != ST_IDLE);
    done_out  = (state_q == ST_DONE);
    eval_out  = (state_q == ST_EVAL);
    pre_out   = (state_q != ST_EVAL);
    load_out  = (state_q == ST_EVAL) && (cnt_q == c_EVAL_LAST);
    first_out = w_active && (round_q == 4'd0);
    last_out  = w_active && (round_q == c_NR);
    round_out = round_q;
  end

  wddl_rcon_gen u_rcon (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .clear_i   (w_rcon_clear),
    .advance_i (w_rcon_adv),
    .rcon_o    (rcon_out)
  );

endmodule
`default_nettype wire

// File: doc/wddl_round_seq.md
Name: wddl_round_seq

Overview:
Phase and round sequencer for the WDDL AES-128 round datapath built from the dual-rail XOR trees and S-box. Alternates every round between a precharge phase, where all dual-rail inputs are forced to 0/0, and an evaluate phase, where the complementary rails are driven. Tracks the round index and generates the round constant. Provides round-type selects and the state-register capture strobe. Sits between the AES top-level start/done handshake and the WDDL datapath/key-schedule muxes.

Parameters:
NR, 10, number of AES rounds after the initial AddRoundKey (round indices 0..NR).
PRE_CYC, 1, clock cycles per precharge phase (>=1).
EVAL_CYC, 1, clock cycles per evaluate phase (>=1).

Ports:
clk_in  input  1  clock; all logic on the rising edge.
rst_in  input  1  synchronous reset, active-high.
start_in  input  1  start request; accepted only in IDLE.
busy_out  output  1  high from the cycle after acceptance through the DONE cycle.
done_out  output  1  one-cycle pulse after the last round's capture.
pre_out  output  1  precharge: the datapath forces both rails of every input to 0.
eval_out  output  1  evaluate phase active; the complement of pre_out while busy.
load_out  output  1  state/key register capture enable, high on the last evaluate cycle of each round.
round_out  output  4  current round index, 0..NR.
rcon_out  output  8  round constant for the current round.
first_out  output  1  round 0: AddRoundKey only.
last_out  output  1  round NR: MixColumns bypassed.

Behaviour:
- Interface (already decided): one clock, clk_in; synchronous active-high reset, rst_in.
- Reset values: busy 0, done 0, pre 1, eval 0, load 0, round 0, rcon 0x00, first 0, last 0. State is IDLE. Phase counter is 0.
- States:
  - IDLE: pre_out=1; no other strobes. start_in=1 moves to PRE with round=0 and first=1.
  - PRE: pre_out=1; phase counter counts 0..PRE_CYC-1, then moves to EVAL with the counter cleared.
  - EVAL: eval_out=1, pre_out=0; counts 0..EVAL_CYC-1. load_out=1 only when count==EVAL_CYC-1.
    - On the last EVAL cycle with round==NR, move to DONE.
    - On the last EVAL cycle otherwise, increment round and move to PRE.
  - DONE: done_out=1, pre_out=1, busy_out=1 for exactly one cycle, then IDLE. round_out holds NR in DONE.
- Round-type selects:
  - first_out = (round==0) in PRE and EVAL.
  - last_out = (round==NR) in PRE and EVAL.
  - Both are 0 in IDLE and DONE.
- Precharge coverage: no cycle has pre_out=0 outside EVAL. Every evaluate phase is preceded by at least PRE_CYC precharge cycles, including between consecutive runs.
- rcon_out sequence:
  - Round 0: 0x00.
  - Round 1: 0x01.
  - Each later increment applies xtime: shift left by 1, XOR 0x1B if the old bit 7 was set.
  - Rounds 1..10 therefore give 01 02 04 08 10 20 40 80 1B 36.
  - rcon_out returns to 0x00 on entering IDLE.
- Latency: with start_in sampled high at edge E0, busy_out=1 from E0.
  - PRE/EVAL run for (NR+1)*(PRE_CYC+EVAL_CYC) cycles.
  - done_out is high during the next cycle.
  - Defaults: 22 PRE/EVAL cycles, done in the 23rd cycle after E0, and 11 load_out pulses.
- start_in while busy (including DONE) is ignored and not queued. start_in held high keeps restarting from IDLE, one cycle after each DONE.
- Reset mid-run: the next edge returns to IDLE with reset values. No load_out or done_out is issued after rst_in is sampled. Reset has priority over start_in.
- Width rules:
  - Phase counter is clog2(max(PRE_CYC,EVAL_CYC)+1) bits.
  - round_out is 4 bits; NR>15 is unsupported.
  - rcon is 8-bit with GF(2^8) reduction polynomial 0x11B.

Decomposition:
- Shared package wddl_aes_pkg holds:
  - the state encoding (IDLE, PRE, EVAL, DONE);
  - the constants AES_NR=10 and RCON_POLY=8'h1B;
  - an xtime function.
- One sub-module, wddl_rcon_gen:
  - 8-bit register with clear and advance inputs;
  - first advance from the cleared state yields 0x01; later advances apply xtime.

Test Plan:
- Reset with defaults → pre=1, busy=0, round=0, rcon=00; no strobes for 10 idle cycles.
- Single start pulse, defaults → 11 load pulses at round 0..10; rcon seen at load = 00,01,02,04,08,10,20,40,80,1B,36; done one cycle 23 cycles after the start edge; busy low the cycle after.
- PRE_CYC=2, EVAL_CYC=3 → each round is 2 pre cycles then 3 eval cycles, load on the 3rd eval cycle; done after 55 cycles; first=1 only in round 0, last=1 only in round 10.
- start_in pulsed at rounds 3 and 7 and during DONE → ignored; sequence identical to the single-start case.
- rst_in asserted in round 5 EVAL, one cycle before load → no load that cycle; next cycle is IDLE with reset values; a fresh start runs a full 11-round sequence.
- start_in held high continuously → back-to-back runs separated by one IDLE precharge cycle; pre_out never low outside EVAL (checked by assertion).
